// File: rtl/rep3_serial_tx_pkg.sv
// Shared constants for the rate-1/3 repetition-code serial link.
// The matching receiver imports the same header.
package rep3_serial_tx_pkg;

   localparam logic [1:0] RTX_IDLE  = 2'd0;
   localparam logic [1:0] RTX_START = 2'd1;
   localparam logic [1:0] RTX_DATA  = 2'd2;

   localparam int RTX_REP = 3;

endpackage

// File: rtl/rep3_cycle_counter.sv
// Mod-3 repetition counter with synchronous clear and terminal-count flag.
// The flag marks the last copy of the current symbol.
module rep3_cycle_counter
   import rep3_serial_tx_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic tc
);

   logic [1:0] rep_cnt;

   assign tc = (rep_cnt == 2'(RTX_REP - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt <= 2'd0;
      end else if (clear) begin
         rep_cnt <= 2'd0;
      end else if (en) begin
         rep_cnt <= tc ? 2'd0 : rep_cnt + 2'd1;
      end
   end

endmodule

// File: rtl/rep3_serial_tx.sv
// Serial transmitter for a rate-1/3 repetition code: a start symbol and then
// the data bits LSB first, with each symbol sent on three consecutive cycles.
module rep3_serial_tx
   import rep3_serial_tx_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_val,
   output logic              in_rdy,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_val,
   output logic              out_bit,
   output logic              busy
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = RTX_IDLE,
      ST_START = RTX_START,
      ST_DATA  = RTX_DATA
   } state_t;

   state_t            state, state_next;
   logic [DATA_W-1:0] shreg, shreg_next;
   logic [BW-1:0]     bit_cnt, bit_cnt_next;
   logic              rep_tc;
   logic              last_bit;
   logic              xfer;

   // Holding the counter clear while idle means every frame starts on copy 0;
   // all other state changes happen on the terminal count, where it wraps anyway.
   rep3_cycle_counter u_rep_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (state == ST_IDLE),
      .en    (1'b1),
      .tc    (rep_tc)
   );

   assign last_bit = (bit_cnt == LAST_BIT);
   assign in_rdy   = (state == ST_IDLE) || ((state == ST_DATA) && last_bit && rep_tc);
   assign xfer     = in_val && in_rdy;
   assign busy     = out_val;

   always_comb begin
      state_next   = state;
      shreg_next   = shreg;
      bit_cnt_next = bit_cnt;
      case (state)
         ST_IDLE: begin
            if (xfer) begin
               state_next   = ST_START;
               shreg_next   = in_data;
               bit_cnt_next = '0;
            end
         end
         ST_START: begin
            if (rep_tc) begin
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (rep_tc) begin
               if (last_bit) begin
                  bit_cnt_next = '0;
                  if (xfer) begin
                     state_next = ST_START;
                     shreg_next = in_data;
                  end else begin
                     state_next = ST_IDLE;
                     shreg_next = shreg >> 1;
                  end
               end else begin
                  shreg_next   = shreg >> 1;
                  bit_cnt_next = bit_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // The line outputs are computed from the next state so they leave a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         out_val <= 1'b0;
         out_bit <= 1'b0;
      end else begin
         state   <= state_next;
         shreg   <= shreg_next;
         bit_cnt <= bit_cnt_next;
         out_val <= (state_next != ST_IDLE);
         out_bit <= (state_next == ST_START) || ((state_next == ST_DATA) && shreg_next[0]);
      end
   end

endmodule
